// File: rtl/socket_transport_sequencer_if.sv
// Move-instruction, register-file and destination-socket signals of the transport sequencer.
// The slave modport is the sequencer side; master is the fetch/unit/register-file side.
interface socket_transport_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 13,
  parameter int NUM_DST = 14
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [2*WIDTH-1:0]       instruction;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [WIDTH-2:0]         rf_read_addr;
  logic [WIDTH-1:0]         rf_read_data;
  logic                     rf_write;
  logic [WIDTH-2:0]         rf_write_addr;
  logic [WIDTH-1:0]         rf_write_data;
  logic [NUM_DST-1:0]       dst_valid;
  logic [NUM_DST-1:0]       dst_ready;
  logic [WIDTH-1:0]         dst_data;
  logic                     illegal;
  logic                     illegal_clear;
  logic                     busy;

  modport slave (
    input  instr_valid, instruction, src_data, rf_read_data, dst_ready, illegal_clear,
    output instr_ready, rf_read_addr, rf_write, rf_write_addr, rf_write_data,
           dst_valid, dst_data, illegal, busy
  );

  modport master (
    output instr_valid, instruction, src_data, rf_read_data, dst_ready, illegal_clear,
    input  instr_ready, rf_read_addr, rf_write, rf_write_addr, rf_write_data,
           dst_valid, dst_data, illegal, busy
  );
endinterface

// File: rtl/socket_transport_sequencer.sv
// Sequential socket decoder: decodes one move, fetches the source from a unit or the
// register file, range-checks it and delivers it to a unit input or the register file.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a move; instr_ready unless illegal is set
// READ    | register source: rf_read_addr driven, data captured at edge
// DELIVER | rf_write strobe, out-of-range flag, or dst_valid until ready
module socket_transport_sequencer #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 13,
  parameter int NUM_DST = 14,
  parameter logic [NUM_DST*WIDTH-1:0] DST_MAX = '1
) (
  input  logic clock,
  input  logic reset,
  socket_transport_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DELIVER} state_e;

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d, illegal_set;
  logic               over_q, over_d;
  logic [WIDTH-1:0]   alpha_q, alpha_d;
  logic [WIDTH-2:0]   rd_addr_q, rd_addr_d;
  logic [WIDTH-2:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [WIDTH-1:0]   dst_data_q, dst_data_d;

  logic [WIDTH-1:0]   alpha, omega, src_sel;
  logic [WIDTH-1:0]   ent_dst, ent_data, ent_max;
  logic               dst_ok, src_ok, instr_ready, accept, enter, rf_write;
  logic [NUM_DST-1:0] dst_hot, dst_valid;

  assign alpha       = bus.instruction[WIDTH-1:0];
  assign omega       = bus.instruction[2*WIDTH-1:WIDTH];
  assign instr_ready = (state_q == IDLE) & ~illegal_q;
  assign accept      = bus.instr_valid & instr_ready;
  assign dst_ok      = alpha[WIDTH-1] | ((alpha != '0) && (alpha <= WIDTH'(NUM_DST)));
  assign src_ok      = omega[WIDTH-1] | ((omega != '0) && (omega <= WIDTH'(NUM_SRC)));

  always_comb begin
    src_sel = '0;
    for (int s = 1; s <= NUM_SRC; s++)
      if (omega == WIDTH'(s)) src_sel = bus.src_data[(s-1)*WIDTH +: WIDTH];
  end

  // Entry into DELIVER comes either straight from IDLE (unit source) or from READ.
  assign ent_dst  = (state_q == IDLE) ? alpha   : alpha_q;
  assign ent_data = (state_q == IDLE) ? src_sel : bus.rf_read_data;

  always_comb begin
    ent_max = '1;
    for (int d = 1; d <= NUM_DST; d++)
      if (ent_dst == WIDTH'(d)) ent_max = DST_MAX[(d-1)*WIDTH +: WIDTH];
  end

  always_comb begin
    dst_hot = '0;
    for (int d = 1; d <= NUM_DST; d++)
      dst_hot[d-1] = (alpha_q == WIDTH'(d));
  end

  always_comb begin
    state_d     = state_q;
    alpha_d     = alpha_q;
    over_d      = over_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    dst_data_d  = dst_data_q;
    illegal_set = 1'b0;
    enter       = 1'b0;
    rf_write    = 1'b0;
    dst_valid   = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alpha == '0) begin
            illegal_set = (omega != WIDTH'(1));
          end else if (!dst_ok || !src_ok) begin
            illegal_set = 1'b1;
          end else if (omega[WIDTH-1]) begin
            rd_addr_d = omega[WIDTH-2:0];
            alpha_d   = alpha;
            state_d   = READ;
          end else begin
            enter = 1'b1;
          end
        end
      end
      READ: enter = 1'b1;
      DELIVER: begin
        if (alpha_q[WIDTH-1]) begin
          rf_write = 1'b1;
          state_d  = IDLE;
        end else if (over_q) begin
          illegal_set = 1'b1;
          state_d     = IDLE;
        end else begin
          dst_valid = dst_hot;
          if (|(dst_hot & bus.dst_ready)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      state_d = DELIVER;
      alpha_d = ent_dst;
      if (ent_dst[WIDTH-1]) begin
        over_d    = 1'b0;
        wr_addr_d = ent_dst[WIDTH-2:0];
        wr_data_d = ent_data;
      end else begin
        over_d = (ent_data > ent_max);
        if (ent_data <= ent_max) dst_data_d = ent_data;
      end
    end
  end

  // A set event in the same cycle as illegal_clear keeps the flag set.
  assign illegal_d = illegal_set ? 1'b1 : (bus.illegal_clear ? 1'b0 : illegal_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      illegal_q  <= 1'b0;
      over_q     <= 1'b0;
      alpha_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      over_q     <= over_d;
      alpha_q    <= alpha_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign bus.instr_ready   = instr_ready;
  assign bus.rf_read_addr  = rd_addr_q;
  assign bus.rf_write      = rf_write;
  assign bus.rf_write_addr = wr_addr_q;
  assign bus.rf_write_data = wr_data_q;
  assign bus.dst_valid     = dst_valid;
  assign bus.dst_data      = dst_data_q;
  assign bus.illegal       = illegal_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_socket_transport_sequencer.sv
// Bench for socket_transport_sequencer: directed vector table, hand sequences for
// illegal/reset corners, and random moves checked against a behavioural move model.
module tb_socket_transport_sequencer;
  localparam int W  = 8;
  localparam int NS = 13;
  localparam int ND = 14;
  // dst5 bound 02, dst7 bound 80, all others FF
  localparam logic [ND*W-1:0] DMAX = {{7{8'hFF}}, 8'h80, 8'hFF, 8'h02, {4{8'hFF}}};

  typedef struct packed {
    int kind;     // 0 none, 1 register write, 2 unit delivery
    int cyc;      // cycles after acceptance edge
    int addr;
    int data;
    int hot;
    int vcyc;     // cycles dst_valid was high
    int wcnt;     // rf_write strobes seen
    int illegal;
    int rdaddr;   // rf_read_addr in the READ cycle, -1 when not applicable
    int unstable;
  } res_t;

  typedef struct packed {
    logic [15:0] instr;
    int          rdy;
    res_t        exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  logic [W-1:0] rf [128];
  logic [W-1:0] srcv [1:NS];
  int dmax_m [1:ND];

  socket_transport_sequencer_if #(.WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND)) bus ();

  socket_transport_sequencer #(.WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .DST_MAX(DMAX)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.rf_read_data = rf[bus.rf_read_addr];
  always_comb begin
    bus.src_data = '0;
    for (int s = 1; s <= NS; s++) bus.src_data[(s-1)*W +: W] = srcv[s];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic res_t mk(int kind, int cyc, int addr, int data, int hot, int vcyc,
                              int ill, int rdaddr);
    res_t r;
    r = '0;
    r.kind = kind; r.cyc = cyc; r.addr = addr; r.data = data; r.hot = hot;
    r.vcyc = vcyc; r.wcnt = (kind == 1) ? 1 : 0; r.illegal = ill; r.rdaddr = rdaddr;
    return r;
  endfunction

  // What one move should do, from the socket rules alone.
  function automatic res_t model(logic [15:0] ins, int rdy);
    res_t r;
    int alpha, omega, data, lat;
    bit dreg, sreg;
    r = '0;
    r.rdaddr = -1;
    alpha = int'(ins[7:0]);
    omega = int'(ins[15:8]);
    if (alpha == 0) begin
      r.illegal = (omega != 1) ? 1 : 0;
      return r;
    end
    dreg = (alpha >= 128);
    sreg = (omega >= 128);
    if ((!dreg && alpha > ND) || (!sreg && (omega == 0 || omega > NS))) begin
      r.illegal = 1;
      return r;
    end
    data = sreg ? int'(rf[omega-128]) : int'(srcv[omega]);
    lat  = sreg ? 2 : 1;
    if (sreg) r.rdaddr = omega - 128;
    if (dreg) begin
      r.kind = 1; r.cyc = lat; r.addr = alpha - 128; r.data = data; r.wcnt = 1;
    end else if (data > dmax_m[alpha]) begin
      r.illegal = 1;
    end else begin
      r.kind = 2; r.cyc = lat; r.hot = 1 << (alpha - 1); r.data = data; r.vcyc = rdy + 1;
    end
    return r;
  endfunction

  task automatic do_move(input logic [15:0] ins, input int rdy, output res_t o);
    int first, k;
    bit done;
    logic [ND-1:0] rnd, hb;
    o = '0;
    o.rdaddr = -1;
    first = -1;
    done = 0;
    k = 0;
    while (!bus.instr_ready && k < 10) begin tick(); k++; end
    check("ready_before_move", int'(bus.instr_ready), 1);
    bus.instr_valid = 1'b1;
    bus.instruction = ins;
    tick();
    bus.instr_valid = 1'b0;
    bus.instruction = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (c == 1 && ins[15] && bus.busy) o.rdaddr = int'(bus.rf_read_addr);
      if (bus.rf_write) begin
        o.wcnt++;
        if ((o.kind & 1) == 0) begin
          o.kind |= 1; o.cyc = c;
          o.addr = int'(bus.rf_write_addr); o.data = int'(bus.rf_write_data);
        end
      end
      rnd = ND'($urandom);
      if (|bus.dst_valid) begin
        hb = bus.dst_valid;
        if (first < 0) begin
          first = c; o.kind |= 2; o.cyc = c; o.hot = int'(hb); o.data = int'(bus.dst_data);
        end else if (int'(hb) != o.hot || int'(bus.dst_data) != o.data) begin
          o.unstable = 1;
        end
        o.vcyc++;
        bus.dst_ready = (rnd & ~hb) | ((c - first >= rdy) ? hb : '0);
      end else begin
        bus.dst_ready = rnd;
      end
      if (!bus.busy) begin
        o.illegal = int'(bus.illegal);
        done = 1;
        break;
      end
      tick();
    end
    check("move_completes", int'(done), 1);
    bus.dst_ready = '0;
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    check({tag, ".kind"},     o.kind,     e.kind);
    check({tag, ".cycle"},    o.cyc,      e.cyc);
    check({tag, ".addr"},     o.addr,     e.addr);
    check({tag, ".data"},     o.data,     e.data);
    check({tag, ".dst_hot"},  o.hot,      e.hot);
    check({tag, ".vcycles"},  o.vcyc,     e.vcyc);
    check({tag, ".wstrobes"}, o.wcnt,     e.wcnt);
    check({tag, ".illegal"},  o.illegal,  e.illegal);
    check({tag, ".rd_addr"},  o.rdaddr,   e.rdaddr);
    check({tag, ".stable"},   o.unstable, 0);
  endtask

  task automatic clear_illegal(input string tag);
    check({tag, ".ready_while_illegal"}, int'(bus.instr_ready), 0);
    bus.illegal_clear = 1'b1;
    tick();
    bus.illegal_clear = 1'b0;
    check({tag, ".illegal_cleared"}, int'(bus.illegal), 0);
    check({tag, ".ready_after_clear"}, int'(bus.instr_ready), 1);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] ins, input int rdy,
                               input res_t e);
    res_t o;
    do_move(ins, rdy, o);
    compare(tag, o, e);
    if (bus.illegal) clear_illegal(tag);
  endtask

  vec_t vecs[14];

  initial begin
    res_t o, e;
    logic [15:0] ins;
    int a, b, sel;

    for (int i = 0; i < 128; i++) rf[i] = W'(i) ^ 8'hA5;
    rf[0] = 8'h77; rf[1] = 8'hC3; rf[3] = 8'h11;
    for (int s = 1; s <= NS; s++) srcv[s] = 8'h40 + W'(s);
    srcv[2] = 8'h5A; srcv[3] = 8'h03; srcv[13] = 8'h02;
    for (int d = 1; d <= ND; d++) dmax_m[d] = 255;
    dmax_m[5] = 2; dmax_m[7] = 128;

    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.dst_ready = '0;
    bus.illegal_clear = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst.instr_ready", int'(bus.instr_ready), 1);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.illegal", int'(bus.illegal), 0);
    check("rst.dst_valid", int'(bus.dst_valid), 0);
    check("rst.rf_write", int'(bus.rf_write), 0);
    check("rst.dst_data", int'(bus.dst_data), 0);
    check("rst.rf_write_data", int'(bus.rf_write_data), 0);

    vecs[0]  = '{16'h0285, 0, mk(1, 1, 5, 'h5A, 0, 0, 0, -1)};
    vecs[1]  = '{16'h8304, 3, mk(2, 2, 0, 'h11, 'h8, 4, 0, 3)};
    vecs[2]  = '{16'h0305, 0, mk(0, 0, 0, 0, 0, 0, 1, -1)};
    vecs[3]  = '{16'h0100, 0, mk(0, 0, 0, 0, 0, 0, 0, -1)};
    vecs[4]  = '{16'h0000, 0, mk(0, 0, 0, 0, 0, 0, 1, -1)};
    vecs[5]  = '{16'h010F, 0, mk(0, 0, 0, 0, 0, 0, 1, -1)};
    vecs[6]  = '{16'h0E01, 0, mk(0, 0, 0, 0, 0, 0, 1, -1)};
    vecs[7]  = '{16'h8182, 0, mk(1, 2, 2, 'hC3, 0, 0, 0, 1)};
    vecs[8]  = '{16'h0201, 0, mk(2, 1, 0, 'h5A, 'h1, 1, 0, -1)};
    vecs[9]  = '{16'h020E, 1, mk(2, 1, 0, 'h5A, 'h2000, 2, 0, -1)};
    vecs[10] = '{16'h0D05, 0, mk(2, 1, 0, 'h02, 'h10, 1, 0, -1)};
    vecs[11] = '{16'h8085, 0, mk(1, 2, 5, 'h77, 0, 0, 0, 0)};
    vecs[12] = '{16'h0307, 2, mk(2, 1, 0, 'h03, 'h40, 3, 0, -1)};
    vecs[13] = '{16'h0E85, 0, mk(0, 0, 0, 0, 0, 0, 1, -1)};
    for (int i = 0; i < 14; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rdy, vecs[i].exp);

    // illegal set and illegal_clear in the same cycle: set wins
    bus.instr_valid = 1'b1;
    bus.instruction = 16'h0000;
    bus.illegal_clear = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.illegal_clear = 1'b0;
    check("set_wins.illegal", int'(bus.illegal), 1);
    tick();
    check("set_wins.sticky", int'(bus.illegal), 1);
    clear_illegal("set_wins");

    for (int n = 0; n < 250; n++) begin
      for (int s = 1; s <= NS; s++) srcv[s] = W'($urandom);
      if ($urandom_range(0, 3) == 0) srcv[$urandom_range(1, NS)] = W'($urandom_range(0, 3));
      rf[$urandom_range(0, 127)] = W'($urandom);
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 0 : (sel <= 5) ? $urandom_range(1, ND) :
          (sel == 6) ? $urandom_range(ND + 1, 127) : $urandom_range(128, 255);
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? $urandom_range(0, 2) : (sel <= 5) ? $urandom_range(1, NS) :
          (sel == 6) ? $urandom_range(NS + 1, 127) : $urandom_range(128, 255);
      ins = {8'(b), 8'(a)};
      sel = $urandom_range(0, 3);
      e = model(ins, sel);
      run_and_check($sformatf("rnd%0d", n), ins, sel, e);
    end

    // leave non-zero data outputs, then reset mid-delivery
    run_and_check("pre_rst_a", 16'h0285, 0, model(16'h0285, 0));
    run_and_check("pre_rst_b", 16'h8304, 0, model(16'h8304, 0));
    bus.instr_valid = 1'b1;
    bus.instruction = 16'h0201;
    tick();
    bus.instr_valid = 1'b0;
    check("midrst.dst_valid_before", int'(bus.dst_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.dst_valid", int'(bus.dst_valid), 0);
    check("midrst.busy", int'(bus.busy), 0);
    check("midrst.illegal", int'(bus.illegal), 0);
    check("midrst.rf_write", int'(bus.rf_write), 0);
    check("midrst.rf_read_addr", int'(bus.rf_read_addr), 0);
    check("midrst.rf_write_addr", int'(bus.rf_write_addr), 0);
    check("midrst.rf_write_data", int'(bus.rf_write_data), 0);
    check("midrst.dst_data", int'(bus.dst_data), 0);
    tick();
    check("midrst.stays_idle", int'(bus.dst_valid), 0);
    check("midrst.ready", int'(bus.instr_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/socket_transport_sequencer.md
Name: socket_transport_sequencer

Overview:
Parametrised, sequential successor to the combinational socket decoder of the transport-triggered core. It accepts one move instruction per handshake and decodes a destination socket (alpha) and a source socket (omega). It reads the source from a functional-unit output bus or the register file, range-checks it per destination, and then delivers it to a unit input (with valid/ready back-pressure) or to the register file. It sits between instruction fetch and the functional units and replaces direct combinational socket wiring.

Parameters:
WIDTH, 8, socket/data width; instruction is 2*WIDTH bits; register address is WIDTH-1 bits
NUM_SRC, 13, number of unit source sockets (ids 1..NUM_SRC); must be < 2**(WIDTH-1)
NUM_DST, 14, number of unit destination sockets (ids 1..NUM_DST); must be < 2**(WIDTH-1)
DST_MAX, all ones, packed NUM_DST*WIDTH upper bounds; destination d bound at [(d-1)*WIDTH +: WIDTH]

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instruction  in  2*WIDTH  alpha=[WIDTH-1:0] destination id, omega=[2*WIDTH-1:WIDTH] source id
src_data  in  NUM_SRC*WIDTH  unit outputs; source s at [(s-1)*WIDTH +: WIDTH]
rf_read_addr  out  WIDTH-1  register read address
rf_read_data  in  WIDTH  register read data, combinational from rf_read_addr
rf_write  out  1  one-cycle register write strobe
rf_write_addr  out  WIDTH-1  register write address
rf_write_data  out  WIDTH  register write data
dst_valid  out  NUM_DST  one-hot; bit d-1 offers dst_data to destination d
dst_ready  in  NUM_DST  destination acceptance
dst_data  out  WIDTH  delivered value
illegal  out  1  sticky illegal-instruction flag
illegal_clear  in  1  clears illegal
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset forces: state IDLE; illegal=0; dst_valid=0; rf_write=0; rf_read_addr, rf_write_addr, rf_write_data, dst_data and the internal data register = 0. Reset mid-transfer abandons the move; dst_valid is 0 in the cycle after reset is sampled.
- Socket ids: an id with MSB=1 is register id[WIDTH-2:0]. A unit source is 1..NUM_SRC. A unit destination is 1..NUM_DST.
- instr_ready = (state==IDLE) & ~illegal. An instruction is accepted on clock edge T when instr_valid & instr_ready.
- Decode at acceptance, in priority order:
  1. alpha=0, omega=1: nop; stay IDLE.
  2. alpha=0, omega≠1: illegal<=1; stay IDLE.
  3. Destination not a register id and not in 1..NUM_DST, or source not a register id and not in 1..NUM_SRC: illegal<=1; stay IDLE.
  4. Source is a unit: capture its slice; go to DELIVER.
  5. Source is a register: latch address; go to READ.
- READ (one cycle): rf_read_addr = latched address. At end of cycle, capture rf_read_data; go to DELIVER.
- DELIVER, register destination: rf_write=1 for exactly one cycle with the latched address and data; return to IDLE. Register-to-register moves are legal.
- DELIVER, unit destination d:
  - If data > DST_MAX[d] (unsigned): illegal<=1; no dst_valid; return to IDLE.
  - Otherwise dst_valid[d-1]=1 with dst_data held stable until dst_ready[d-1] is sampled high; then return to IDLE. The other dst_ready bits are ignored.
- Latency, unit source: dst_valid or rf_write asserted in cycle T+1.
- Latency, register source: dst_valid or rf_write asserted in cycle T+2.
- Throughput: one instruction per cycle only for nops; otherwise one per completed move.
- illegal: while set, no instruction is accepted. illegal_clear clears it on the next edge. If a set event and illegal_clear coincide, set wins.
- Outputs not active in the current state (rf_write_*, dst_data) hold their last values; dst_valid and rf_write are 0 outside DELIVER.

Test Plan:
- WIDTH=8: instruction {omega=8'h02, alpha=8'h85} with src_data slice 2 = 8'h5A -> cycle T+1: rf_write=1, rf_write_addr=7'h05, rf_write_data=8'h5A for one cycle; instr_ready returns high at T+2.
- Register source to unit: {omega=8'h83, alpha=8'h04}, rf[3]=8'h11, dst_ready[3] low for 3 cycles -> rf_read_addr=3 at T+1; dst_valid=4'b1000 (bit 3) from T+2, held with dst_data=8'h11 until dst_ready[3] is sampled high, then IDLE.
- Range check: DST_MAX for destination 5 = 8'h02, source data 8'h03 -> illegal=1, no dst_valid, instr_ready=0. Pulse illegal_clear -> illegal=0 and instr_ready=1 the next cycle.
- Encodings: 16'h0100 (nop) -> no outputs, stays IDLE. 16'h0000 -> illegal. alpha=NUM_DST+1 -> illegal. omega=NUM_SRC+1 -> illegal.
- Reset asserted while dst_valid is high and dst_ready is low -> next cycle dst_valid=0, state IDLE, illegal=0, all data outputs 0.
- Register to register: {omega=8'h81, alpha=8'h82}, rf[1]=8'hC3 -> rf_write at T+2 with addr=7'h02, data=8'hC3.
